// File: rtl/dma_stream_segmenter.sv
// Re-frames a continuous AXI-Stream into segments of at most C_MAX_BURST beats,
// closing early on source tlast, idle timeout or a software flush.
module dma_stream_segmenter #(
  parameter int C_AXIS_WIDTH    = 64,
  parameter int C_MAX_BURST     = 16,
  parameter int C_TIMEOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                       flush,
  input  logic [C_AXIS_WIDTH-1:0]    s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0]    m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [31:0]                segment_count,
  output logic [31:0]                timeout_count
);

  localparam int SEG_W = $clog2(C_MAX_BURST);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(C_MAX_BURST - 1);

  logic [C_AXIS_WIDTH-1:0]    h_data_q, h_data_d;
  logic                       h_last_q, h_last_d;
  logic                       h_valid_q, h_valid_d;
  logic [C_AXIS_WIDTH-1:0]    o_data_q, o_data_d;
  logic                       o_last_q, o_last_d;
  logic                       o_valid_q, o_valid_d;
  logic [SEG_W-1:0]           seg_cnt_q, seg_cnt_d;
  logic [C_TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [31:0]                seg_total_q, seg_total_d;
  logic [31:0]                tmo_total_q, tmo_total_d;

  logic o_free_s, accept_s, timeout_hit_s, burst_full_s, close_s, move_s, sole_timeout_s;

  assign o_free_s       = !o_valid_q || m_axis_tready;
  assign s_axis_tready  = !h_valid_q || o_free_s;
  assign accept_s       = s_axis_tvalid && s_axis_tready;
  assign timeout_hit_s  = (timeout_cycles != '0) && (idle_cnt_q >= timeout_cycles);
  assign burst_full_s   = (seg_cnt_q == SEG_LAST);
  assign close_s        = h_last_q || burst_full_s || flush_pend_q || timeout_hit_s;
  assign move_s         = h_valid_q && o_free_s && (accept_s || close_s);
  assign sole_timeout_s = timeout_hit_s && !h_last_q && !burst_full_s && !flush_pend_q;

  assign m_axis_tdata  = o_data_q;
  assign m_axis_tlast  = o_last_q;
  assign m_axis_tvalid = o_valid_q;
  assign segment_count = seg_total_q;
  assign timeout_count = tmo_total_q;

  // Next-state for hold/output stages, segment bookkeeping and statistics.
  always_comb begin
    h_data_d     = h_data_q;
    h_last_d     = h_last_q;
    h_valid_d    = h_valid_q;
    o_data_d     = o_data_q;
    o_last_d     = o_last_q;
    o_valid_d    = o_valid_q;
    seg_cnt_d    = seg_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    seg_total_d  = seg_total_q;
    tmo_total_d  = tmo_total_q;

    if (accept_s) begin
      h_data_d  = s_axis_tdata;
      h_last_d  = s_axis_tlast;
      h_valid_d = 1'b1;
    end else if (move_s) begin
      h_valid_d = 1'b0;
    end else begin
      h_valid_d = h_valid_q;
    end

    if (move_s) begin
      o_data_d  = h_data_q;
      o_last_d  = close_s;
      o_valid_d = 1'b1;
      seg_cnt_d = close_s ? '0 : seg_cnt_q + SEG_W'(1);
    end else if (o_valid_q && m_axis_tready) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end

    if (accept_s || move_s) begin
      idle_cnt_d = '0;
    end else if (h_valid_q && (idle_cnt_q != '1)) begin
      idle_cnt_d = idle_cnt_q + C_TIMEOUT_WIDTH'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    // A flush only sticks while a beat is held, so it can never close an empty segment.
    flush_pend_d = h_valid_q && h_valid_d && (flush || (flush_pend_q && !move_s));

    if (move_s && close_s) begin
      seg_total_d = seg_total_q + 32'd1;
      if (sole_timeout_s) begin
        tmo_total_d = tmo_total_q + 32'd1;
      end else begin
        tmo_total_d = tmo_total_q;
      end
    end else begin
      seg_total_d = seg_total_q;
    end
  end

  // State registers; reset discards any held or output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data_q     <= '0;
      h_last_q     <= 1'b0;
      h_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_last_q     <= 1'b0;
      o_valid_q    <= 1'b0;
      seg_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      seg_total_q  <= 32'd0;
      tmo_total_q  <= 32'd0;
    end else begin
      h_data_q     <= h_data_d;
      h_last_q     <= h_last_d;
      h_valid_q    <= h_valid_d;
      o_data_q     <= o_data_d;
      o_last_q     <= o_last_d;
      o_valid_q    <= o_valid_d;
      seg_cnt_q    <= seg_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      flush_pend_q <= flush_pend_d;
      seg_total_q  <= seg_total_d;
      tmo_total_q  <= tmo_total_d;
    end
  end

endmodule

// File: doc/dma_stream_segmenter.md
# dma_stream_segmenter

Upstream of the circular S2MM DMA: takes a continuous AXI-Stream of C_AXIS_WIDTH-bit words and re-frames it into bounded segments before the stream reaches the DMA's `s_axis_s2mm` port.
- `m_axis_tlast` is asserted when any of these happens: the segment reaches C_MAX_BURST beats, the source asserts tlast, the stream goes idle for a programmable number of cycles, or software pulses flush.
- Result: every DMA command covers at most one burst, and partial data never sits in the pipeline indefinitely.

## Interface
Parameters:
- C_AXIS_WIDTH, 64, data width of both streams
- C_MAX_BURST, 16, maximum beats per segment; power of two, ≥2
- C_TIMEOUT_WIDTH, 16, width of the idle-timeout setting

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- timeout_cycles  in  C_TIMEOUT_WIDTH  idle cycles before a held beat is closed; 0 disables the timeout
- flush  in  1  one-cycle pulse; closes the current segment
- s_axis_tdata  in  C_AXIS_WIDTH  input data
- s_axis_tlast  in  1  source end-of-frame
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  C_AXIS_WIDTH  output data, to the DMA `s_axis_s2mm`
- m_axis_tlast  out  1  segment end
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- segment_count  out  32  number of segments emitted (counts output beats with tlast)
- timeout_count  out  32  number of segments closed by the timeout

## Operation
Storage:
- Hold register H: data, src_last, valid.
- Output register O: data, last, valid; drives m_axis directly.
- seg_cnt: clog2(C_MAX_BURST) bits; beats already moved into O in the current segment.
- idle_cnt: C_TIMEOUT_WIDTH bits.

Control signals:
- o_free = !O.valid || m_axis_tready.
- s_axis_tready = !H.valid || o_free. The output is purely registered, with no combinational path from tvalid to tready.
- accept = s_axis_tvalid && s_axis_tready.
- close = H.src_last || seg_cnt == C_MAX_BURST-1 || flush_pend || timeout_hit.
- flush_pend: set by flush, cleared when H moves to O.
  - If flush arrives while H is empty, flush_pend is also cleared and no event occurs; a flush never creates an empty beat.
- timeout_hit = timeout_cycles != 0 && idle_cnt >= timeout_cycles.

H→O move occurs when H.valid && o_free && (accept || close):
- O gets H.data, with O.last = close.
- If close, seg_cnt resets to 0; otherwise seg_cnt increments.
- On accept, H is loaded with the new beat; otherwise H.valid clears.

Other updates:
- If accept occurs while H is empty, H is loaded and there is no move.
- If O.valid && m_axis_tready with no move, O.valid clears.
- idle_cnt clears on accept or on a move. It increments, saturating, while H.valid && !accept.
- On a move with close:
  - segment_count increments.
  - timeout_count increments only if timeout_hit && !H.src_last && seg_cnt != C_MAX_BURST-1 && !flush_pend. The timeout counts only when it is the sole reason for closing.
- Counters wrap at 2^32.

## Timing
- Reset values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, both counters 0. seg_cnt, idle_cnt, H, O and flush_pend are all cleared.
- Reset is asynchronous. Asserting it mid-segment discards the H and O contents without emitting them.
- Latency:
  - A beat accepted in cycle N enters H in N+1.
  - It appears on m_axis in N+2 if close holds in N+1; otherwise it appears in the cycle after the next accept.
- Timeout: the last beat of an idle stream appears on m_axis, with tlast, timeout_cycles+2 cycles after its accept edge, provided m_axis_tready=1.
- Simultaneous new accept and timeout_hit: the move happens with close=1 (timeout wins for that beat), and the new beat starts the next segment.
- Back-pressure: while O is stalled, H holds one further beat, and then s_axis_tready=0. Throughput is 1 beat/cycle when m_axis_tready=1.
- timeout_cycles is sampled every cycle. Lowering it below idle_cnt triggers an immediate close.

## Test plan
- Continuous 40 beats, tlast=0, tready=1, timeout=0:
  - Expect tlast on output beats 16 and 32; beats 33–40 remain unclosed (beat 40 stays in H).
  - segment_count=2, timeout_count=0.
- 5 beats then idle, timeout_cycles=10:
  - Beat 5 is emitted with tlast exactly 12 cycles after its accept.
  - segment_count=1, timeout_count=1.
- Source tlast on beat 3:
  - Output beat 3 carries tlast, seg_cnt restarts, and the next 16 beats close at beat 19.
- m_axis_tready toggled in the pattern 1,0,0,1 against continuous input:
  - No data loss or duplication; output sequence equals input; s_axis_tready drops only when both H and O are full.
- flush pulse with 7 beats pending (H full):
  - Beat 7 is emitted with tlast; timeout_count unchanged.
  - A flush with H empty produces no output.
- rst_n asserted with O and H full:
  - m_axis_tvalid=0 asynchronously, s_axis_tready=1.
  - After release, the first 16 new beats form a complete segment.
